// File: rtl/nussinov_pkg.sv
// Shared definitions for the Nussinov kernel.
//   - sequencer state and step-phase encodings
//   - elem_addr : word index -> byte address within the region
//   - base_match: pairing score for two bases
package nussinov_pkg;

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_CALC = 3'd1;
  localparam logic [2:0] S_RD   = 3'd2;
  localparam logic [2:0] S_WR   = 3'd3;
  localparam logic [2:0] S_DONE = 3'd4;

  // Operand fetch order for one (i,j) cell
  localparam logic [3:0] PH_TIJ  = 4'd0;  // table[i][j]     -> acc
  localparam logic [3:0] PH_LEFT = 4'd1;  // table[i][j-1]
  localparam logic [3:0] PH_DOWN = 4'd2;  // table[i+1][j]
  localparam logic [3:0] PH_DIAG = 4'd3;  // table[i+1][j-1]
  localparam logic [3:0] PH_SI   = 4'd4;  // seq[i]
  localparam logic [3:0] PH_SJ   = 4'd5;  // seq[j]
  localparam logic [3:0] PH_K1   = 4'd6;  // table[i][k]
  localparam logic [3:0] PH_K2   = 4'd7;  // table[k+1][j]
  localparam logic [3:0] PH_WR   = 4'd8;  // write acc -> table[i][j]

  function automatic logic [63:0] elem_addr(input logic [63:0] base, input logic [63:0] idx);
    return base + (idx << 2);
  endfunction

  function automatic logic [31:0] base_match(input logic [31:0] a, input logic [31:0] b);
    return ((a + b) == 32'd3) ? 32'd1 : 32'd0;
  endfunction

endpackage

// File: rtl/nussinov_mem_port.sv
// Single-outstanding memory port for the Nussinov kernel.
//   start/we/addr/wdata : request from the sequencer (start only when idle)
//   ack/rdata           : one-cycle pulse after the response is taken; rdata holds read word
//   read_*/write_*      : external request/acknowledge handshake
module nussinov_mem_port
  import nussinov_pkg::*;
#(
  parameter int DATA_WID = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                start,
  input  logic                we,
  input  logic [63:0]         addr,
  input  logic [DATA_WID-1:0] wdata,
  input  logic [63:0]         read_ready,
  input  logic [63:0]         write_ready,
  input  logic [DATA_WID-1:0] read_data,
  output logic                read_enable,
  output logic                write_enable,
  output logic [63:0]         read_addr,
  output logic [63:0]         write_addr,
  output logic [DATA_WID-1:0] write_data,
  output logic                finish_read,
  output logic                finish_write,
  output logic                ack,
  output logic [DATA_WID-1:0] rdata
);

  // Responses only count when a request is actually pending
  assign finish_read  = read_enable  & (read_ready  == 64'd1);
  assign finish_write = write_enable & (write_ready == 64'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      read_enable  <= 1'b0;
      write_enable <= 1'b0;
      read_addr    <= '0;
      write_addr   <= '0;
      write_data   <= '0;
      ack          <= 1'b0;
      rdata        <= '0;
    end else begin
      ack <= 1'b0;
      if (start) begin
        if (we) begin
          write_enable <= 1'b1;
          write_addr   <= addr;
          write_data   <= wdata;
        end else begin
          read_enable <= 1'b1;
          read_addr   <= addr;
        end
      end else if (finish_read) begin
        read_enable <= 1'b0;
        rdata       <= read_data;
        ack         <= 1'b1;
      end else if (finish_write) begin
        write_enable <= 1'b0;
        ack          <= 1'b1;
      end
    end
  end

endmodule

// File: rtl/nussinov_kernel.sv
// Nussinov RNA-folding DP kernel, in-place over a word-addressed region.
//   region: seq[0..N-1] at words 0..N-1, table[r][c] at word N + r*N + c
//   read_*/write_* : one-outstanding request/ack handshake (via nussinov_mem_port)
//   done/returnvalue : completion flag and final table[0][N-1]
//   write_base, num_read : informational only
module nussinov_kernel
  import nussinov_pkg::*;
#(
  parameter int N        = 60,
  parameter int DATA_WID = 32
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [63:0]         read_base,
  input  logic [63:0]         write_base,
  input  logic [63:0]         num_read,
  input  logic [63:0]         read_size_input,
  input  logic [63:0]         read_ready,
  input  logic [63:0]         write_ready,
  input  logic [DATA_WID-1:0] read_data,
  output logic                read_enable,
  output logic                write_enable,
  output logic                finish_read,
  output logic                finish_write,
  output logic                done,
  output logic [63:0]         read_addr,
  output logic [63:0]         write_addr,
  output logic [63:0]         write_size,
  output logic [63:0]         read_size_output,
  output logic [DATA_WID-1:0] write_data,
  output logic [DATA_WID-1:0] returnvalue
);

  localparam int IW = $clog2(N + 1);
  localparam logic [IW-1:0] ONE  = IW'(1);
  localparam logic [IW-1:0] LAST = IW'(N - 1);
  // Row N-1 has no cells, so the sweep starts at row N-2
  localparam logic [IW-1:0] I0   = IW'((N > 1) ? N - 2 : 0);

  logic [2:0]          state;
  logic [3:0]          ph;
  logic [IW-1:0]       i, j, k;
  logic [DATA_WID-1:0] acc, tmp, sa;
  logic [63:0]         idx;
  logic                start, ack;
  logic [DATA_WID-1:0] rdata;
  logic                unused_inputs;

  assign unused_inputs = ^{write_base, num_read};

  function automatic logic [63:0] tix(input logic [IW-1:0] r, input logic [IW-1:0] c);
    return 64'(N) + 64'(r) * 64'(N) + 64'(c);
  endfunction

  function automatic logic [DATA_WID-1:0] smax(input logic [DATA_WID-1:0] a,
                                               input logic [DATA_WID-1:0] b);
    return ($signed(a) > $signed(b)) ? a : b;
  endfunction

  always_comb begin
    idx = tix(i, j);
    case (ph)
      PH_LEFT: idx = tix(i, j - ONE);
      PH_DOWN: idx = tix(i + ONE, j);
      PH_DIAG: idx = tix(i + ONE, j - ONE);
      PH_SI:   idx = 64'(i);
      PH_SJ:   idx = 64'(j);
      PH_K1:   idx = tix(i, k);
      PH_K2:   idx = tix(k + ONE, j);
      default: ;
    endcase
  end

  // CALC lasts exactly one cycle, so start is a single-cycle pulse
  assign start = (state == S_CALC);

  nussinov_mem_port #(.DATA_WID(DATA_WID)) u_port (
    .clk          (clk),
    .reset        (reset),
    .start        (start),
    .we           (ph == PH_WR),
    .addr         (elem_addr(read_base, idx)),
    .wdata        (acc),
    .read_ready   (read_ready),
    .write_ready  (write_ready),
    .read_data    (read_data),
    .read_enable  (read_enable),
    .write_enable (write_enable),
    .read_addr    (read_addr),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .finish_read  (finish_read),
    .finish_write (finish_write),
    .ack          (ack),
    .rdata        (rdata)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state            <= S_IDLE;
      ph               <= PH_TIJ;
      i                <= '0;
      j                <= '0;
      k                <= '0;
      acc              <= '0;
      tmp              <= '0;
      sa               <= '0;
      done             <= 1'b0;
      returnvalue      <= '0;
      write_size       <= '0;
      read_size_output <= '0;
    end else begin
      write_size       <= read_size_input;
      read_size_output <= read_size_input;
      case (state)
        S_IDLE: begin
          i     <= I0;
          j     <= LAST;
          k     <= '0;
          ph    <= PH_TIJ;
          state <= S_CALC;
        end
        S_CALC: state <= (ph == PH_WR) ? S_WR : S_RD;
        S_RD: if (ack) begin
          state <= S_CALC;
          case (ph)
            PH_TIJ: begin
              acc <= rdata;
              ph  <= PH_LEFT;
              // Single-element table: nothing to fold, report it directly
              if (N == 1) begin
                returnvalue <= rdata;
                done        <= 1'b1;
                state       <= S_DONE;
              end
            end
            PH_LEFT: begin acc <= smax(acc, rdata); ph <= PH_DOWN; end
            PH_DOWN: begin acc <= smax(acc, rdata); ph <= PH_DIAG; end
            PH_DIAG: begin
              if (i < j - ONE) begin
                tmp <= rdata;
                ph  <= PH_SI;
              end else begin
                // j == i+1: no pairing term and an empty k range
                acc <= smax(acc, rdata);
                ph  <= PH_WR;
              end
            end
            PH_SI: begin sa <= rdata; ph <= PH_SJ; end
            PH_SJ: begin
              acc <= smax(acc, tmp + DATA_WID'(base_match(32'(sa), 32'(rdata))));
              k   <= i + ONE;
              ph  <= PH_K1;
            end
            PH_K1: begin tmp <= rdata; ph <= PH_K2; end
            PH_K2: begin
              acc <= smax(acc, tmp + rdata);
              if (k + ONE < j) begin
                k  <= k + ONE;
                ph <= PH_K1;
              end else begin
                ph <= PH_WR;
              end
            end
            default: ph <= PH_TIJ;
          endcase
        end
        S_WR: if (ack) begin
          state <= S_CALC;
          ph    <= PH_TIJ;
          if (j < LAST) begin
            j <= j + ONE;
          end else if (i == '0) begin
            returnvalue <= acc;
            done        <= 1'b1;
            state       <= S_DONE;
          end else begin
            i <= i - ONE;
            j <= i;
          end
        end
        S_DONE: ;
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_nussinov_kernel.sv
// Scoreboard bench for nussinov_kernel (N=4) plus a small N=1 instance.
module tb_nussinov_kernel;

  localparam int N  = 4;
  localparam int NW = N + N * N;
  localparam logic [63:0] BASE = 64'h1000;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        reset = 1'b1;
  logic [63:0] read_base = BASE, write_base = 64'd0, num_read = 64'(NW);
  logic [63:0] read_size_input = 64'd4, read_ready = 64'd0, write_ready = 64'd0;
  logic [31:0] read_data = 32'd0;
  logic        read_enable, write_enable, finish_read, finish_write, done;
  logic [63:0] read_addr, write_addr, write_size, read_size_output;
  logic [31:0] write_data, returnvalue;

  nussinov_kernel #(.N(N), .DATA_WID(32)) dut (
    .clk(clk), .reset(reset), .read_base(read_base), .write_base(write_base),
    .num_read(num_read), .read_size_input(read_size_input), .read_ready(read_ready),
    .write_ready(write_ready), .read_data(read_data), .read_enable(read_enable),
    .write_enable(write_enable), .finish_read(finish_read), .finish_write(finish_write),
    .done(done), .read_addr(read_addr), .write_addr(write_addr), .write_size(write_size),
    .read_size_output(read_size_output), .write_data(write_data), .returnvalue(returnvalue)
  );

  // N=1 instance
  logic        reset1 = 1'b1;
  logic [63:0] rr1 = 64'd0, wr1 = 64'd0;
  logic [31:0] rd1 = 32'd0;
  logic        ren1, wen1, fr1, fw1, done1;
  logic [63:0] ra1, wa1, ws1, rso1;
  logic [31:0] wd1, ret1;

  nussinov_kernel #(.N(1), .DATA_WID(32)) dut1 (
    .clk(clk), .reset(reset1), .read_base(read_base), .write_base(write_base),
    .num_read(64'd2), .read_size_input(read_size_input), .read_ready(rr1),
    .write_ready(wr1), .read_data(rd1), .read_enable(ren1),
    .write_enable(wen1), .finish_read(fr1), .finish_write(fw1),
    .done(done1), .read_addr(ra1), .write_addr(wa1), .write_size(ws1),
    .read_size_output(rso1), .write_data(wd1), .returnvalue(ret1)
  );

  typedef struct { logic [63:0] a; logic [31:0] d; } wr_t;
  wr_t exp_q[$];
  wr_t e;

  logic [31:0] mem [0:NW-1];
  int  lat = 3;
  bit  spur = 1'b0;
  int  rcnt = 0, wcnt = 0;
  int  vecs = 0, errs = 0, proto = 0, nwr = 0;
  int  n1_reads = 0, n1_writes = 0;
  bit  got_first = 1'b0;
  logic [63:0] first_addr = 64'd0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    vecs++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  function automatic int widx(input logic [63:0] a);
    logic [63:0] w;
    w = (a - BASE) >> 2;
    return (w < 64'(NW)) ? int'(w) : 0;
  endfunction

  // Memory responder: answers after `lat` cycles, optional stray read_ready in gaps
  initial begin
    forever begin
      @(posedge clk); #1;
      read_ready  = 64'd0;
      write_ready = 64'd0;
      if (reset) begin
        rcnt = 0; wcnt = 0;
      end else if (read_enable) begin
        if (rcnt >= lat) begin
          read_ready = 64'd1; read_data = mem[widx(read_addr)]; rcnt = 0;
        end else rcnt++;
      end else if (write_enable) begin
        if (wcnt >= lat) begin
          write_ready = 64'd1; mem[widx(write_addr)] = write_data; wcnt = 0;
        end else wcnt++;
      end else if (spur) begin
        read_ready = 64'd1; read_data = 32'hbad0bad0;
      end
    end
  end

  // Monitor: scoreboard of writes plus handshake invariants
  always @(negedge clk) begin
    if (!reset) begin
      if (read_enable && write_enable) proto++;
      if (finish_read  !== (read_enable  && read_ready  == 64'd1)) proto++;
      if (finish_write !== (write_enable && write_ready == 64'd1)) proto++;
      if (read_enable && !got_first) begin got_first = 1'b1; first_addr = read_addr; end
      if (finish_write) begin
        nwr++;
        if (exp_q.size() == 0) begin
          vecs++; errs++;
          $display("FAIL wr_unexpected: got addr %0h data %0h, expected no write", write_addr, write_data);
        end else begin
          e = exp_q.pop_front();
          chk("wr_addr", write_addr, e.a);
          chk("wr_data", 64'(write_data), 64'(e.d));
        end
      end
    end
    if (!reset1) begin
      if (fr1) n1_reads++;
      if (wen1) n1_writes++;
    end
  end

  task automatic load(input logic [31:0] s0, input logic [31:0] s1,
                      input logic [31:0] s2, input logic [31:0] s3);
    for (int x = 0; x < NW; x++) mem[x] = 32'd0;
    mem[0] = s0; mem[1] = s1; mem[2] = s2; mem[3] = s3;
    exp_q.delete();
    nwr = 0; proto = 0; got_first = 1'b0;
  endtask

  task automatic preset(input int r, input int c, input logic [31:0] v);
    mem[N + r * N + c] = v;
  endtask

  task automatic ew(input int r, input int c, input logic [31:0] d);
    wr_t w;
    w.a = BASE + 64'((N + r * N + c) * 4);
    w.d = d;
    exp_q.push_back(w);
  endtask

  // Cell order is (2,3),(1,2),(1,3),(0,1),(0,2),(0,3)
  task automatic ew6(input logic [31:0] d23, input logic [31:0] d12, input logic [31:0] d13,
                     input logic [31:0] d01, input logic [31:0] d02, input logic [31:0] d03);
    ew(2, 3, d23); ew(1, 2, d12); ew(1, 3, d13);
    ew(0, 1, d01); ew(0, 2, d02); ew(0, 3, d03);
  endtask

  task automatic go();
    reset = 1'b1;
    repeat (2) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic wait_done(input string nm, input logic [31:0] ret);
    int cyc = 0;
    while (done !== 1'b1 && cyc < 3000) begin @(negedge clk); cyc++; end
    chk({nm, "_done"}, 64'(done), 64'd1);
    chk({nm, "_ret"}, 64'(returnvalue), 64'(ret));
    repeat (5) @(negedge clk);
    chk({nm, "_done_held"}, 64'(done), 64'd1);
    chk({nm, "_sb_empty"}, 64'(exp_q.size()), 64'd0);
    chk({nm, "_proto"}, 64'(proto), 64'd0);
    chk({nm, "_t03"}, 64'(mem[N + N - 1]), 64'(ret));
  endtask

  task automatic chk_zero(input string nm);
    chk({nm, "_ren"}, 64'(read_enable), 64'd0);
    chk({nm, "_wen"}, 64'(write_enable), 64'd0);
    chk({nm, "_done"}, 64'(done), 64'd0);
    chk({nm, "_ret"}, 64'(returnvalue), 64'd0);
    chk({nm, "_raddr"}, read_addr, 64'd0);
    chk({nm, "_waddr"}, write_addr, 64'd0);
    chk({nm, "_wdata"}, 64'(write_data), 64'd0);
    chk({nm, "_wsize"}, write_size, 64'd0);
  endtask

  initial begin
    int cyc;

    // 1: alternating bases, zero table
    lat = 3; spur = 1'b0;
    load(1, 2, 1, 2);
    ew6(0, 0, 0, 0, 0, 1);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    chk_zero("rst");
    reset = 1'b0;
    wait_done("t1", 1);
    chk("t1_sizes", write_size, 64'd4);
    chk("t1_rsize", read_size_output, 64'd4);

    // 2: no pairs possible; first request is table[2][3]
    load(0, 0, 0, 0);
    ew6(0, 0, 0, 0, 0, 0);
    go();
    wait_done("t2", 0);
    chk("t2_first_rd", first_addr, BASE + 64'((N + 2 * N + 3) * 4));

    // 3: negative preset is overridden by the zero neighbour
    load(1, 2, 1, 2);
    preset(0, 1, 32'hffff_fffb);
    ew6(0, 0, 0, 0, 0, 1);
    go();
    wait_done("t3", 1);

    // 4/5: fast and slow responders with stray read_ready pulses
    lat = 1; spur = 1'b1;
    load(1, 2, 1, 2);
    ew6(0, 0, 0, 0, 0, 1);
    go();
    wait_done("t4", 1);
    lat = 10;
    load(1, 2, 1, 2);
    ew6(0, 0, 0, 0, 0, 1);
    go();
    wait_done("t5", 1);
    spur = 1'b0; lat = 2;

    // 6: k-split term table[0][1]+table[2][3] = 3+4 dominates
    load(0, 0, 0, 0);
    preset(0, 1, 3); preset(2, 3, 4);
    ew6(4, 0, 4, 3, 3, 7);
    go();
    wait_done("t6", 7);

    // 7: pairing bonus on top of table[1][2]=5 gives 6
    load(1, 2, 1, 2);
    preset(1, 2, 5);
    ew6(0, 5, 5, 0, 5, 6);
    go();
    wait_done("t7", 6);

    // 8: reset after the third write, then a full clean rerun
    load(1, 2, 1, 2);
    ew(2, 3, 0); ew(1, 2, 0); ew(1, 3, 0);
    ew6(0, 0, 0, 0, 0, 1);
    go();
    cyc = 0;
    while (nwr < 3 && cyc < 3000) begin @(negedge clk); cyc++; end
    chk("t8_three_writes", 64'(nwr), 64'd3);
    reset = 1'b1;
    @(negedge clk);
    chk_zero("t8_rst");
    reset = 1'b0;
    wait_done("t8", 1);

    // 9: N=1, one read of table[0][0] and no writes
    reset1 = 1'b1;
    repeat (2) @(negedge clk);
    reset1 = 1'b0;
    cyc = 0;
    while (ren1 !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    chk("n1_ren", 64'(ren1), 64'd1);
    chk("n1_addr", ra1, BASE + 64'd4);
    repeat (2) @(negedge clk);
    rr1 = 64'd1; rd1 = 32'd42;
    @(negedge clk);
    rr1 = 64'd0; rd1 = 32'd0;
    cyc = 0;
    while (done1 !== 1'b1 && cyc < 100) begin @(negedge clk); cyc++; end
    repeat (3) @(negedge clk);
    chk("n1_done", 64'(done1), 64'd1);
    chk("n1_ret", 64'(ret1), 64'd42);
    chk("n1_reads", 64'(n1_reads), 64'd1);
    chk("n1_writes", 64'(n1_writes), 64'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/nussinov_kernel.md
# nussinov_kernel

Compute kernel for the Nussinov RNA-folding dynamic program (Polybench `nussinov`). It sits behind the scratchpad/stream wrapper and works on a word-addressed region through a one-outstanding-request read/write handshake. The region holds the base sequence and the DP table. It updates the table in place, then asserts `done`. The wrapper holds the kernel in reset while it preloads its scratchpad and releases reset to start it.

## Interface
- `N`, default 60: sequence length; the table is N×N.
- `DATA_WID`, default 32: signed element width.
- `clk` in 1: clock.
- `reset` in 1: synchronous, active-high.
- `read_base` in 64: byte base of the region; the kernel reads and writes here.
- `write_base` in 64: ignored by the kernel.
- `num_read` in 64: word count of the region, N+N·N; informational only.
- `read_size_input` in 64: element size in bytes (4).
- `read_ready` in 64: read response valid when ==1; one-cycle pulse.
- `write_ready` in 64: write acknowledge when ==1; one-cycle pulse.
- `read_data` in 32: read response data.
- `read_enable` out 1: read request pending.
- `write_enable` out 1: write request pending.
- `finish_read` out 1: read response consumed.
- `finish_write` out 1: write acknowledge consumed.
- `done` out 1: computation complete.
- `read_addr` out 64: byte address of the read request.
- `write_addr` out 64: byte address of the write request.
- `write_size` out 64: equals `read_size_input`.
- `read_size_output` out 64: equals `read_size_input`.
- `write_data` out 32: data for the write request.
- `returnvalue` out 32: final table[0][N-1].

## Operation
- Memory layout, in words from `read_base`: seq[0..N-1] at index 0..N-1; table[r][c] at index N + r·N + c. Byte address = read_base + (index<<2).
- Loop order: for i = N-1 down to 0, for j = i+1 to N-1, let acc = table[i][j], then:
  - acc = max(acc, table[i][j-1]).
  - If i+1<N: acc = max(acc, table[i+1][j]).
  - If i+1<N and i<j-1: acc = max(acc, table[i+1][j-1] + match(seq[i],seq[j])).
  - If i+1<N and i≥j-1: acc = max(acc, table[i+1][j-1]).
  - For k = i+1 to j-1: acc = max(acc, table[i][k] + table[k+1][j]).
  - Write acc to table[i][j]. This is the only write per (i,j).
- match(a,b) = 1 if a+b == 3, else 0.
- Arithmetic: signed 32-bit max; sums wrap modulo 2^32.
- Every table and seq operand is read from memory when needed; there is no operand caching. Written values are visible to later reads.
- After the last write: `returnvalue` ← the last acc, which is table[0][N-1]. `done` asserts and holds until reset.
- For N=1 there are no iterations: `done` asserts with `returnvalue`=table[0][0], which is read once.
- State machine: IDLE → CALC (step sequencer over i, j, k) → RD (request) → back to CALC; WR → CALC; DONE.
- The kernel leaves IDLE on the first cycle after reset deasserts.

## Timing
- Reset values: all outputs 0 and all counters 0. `write_size` and `read_size_output` are a copy of `read_size_input`, registered each cycle.
- At most one request outstanding. `read_enable` and `write_enable` are never high together.
- Address and data are stable while the enable is high.
- Read: `read_enable` and `read_addr` are registered high and held until the cycle `read_ready`==1.
  - `finish_read` = read_enable & (read_ready==1), combinational.
  - `read_data` is captured on that cycle, and `read_enable` drops the next cycle.
- Write: same scheme with `write_enable`, `write_ready` and `finish_write`.
- Response latency is arbitrary (≥1 cycle). A `read_ready` or `write_ready` with no pending enable is ignored.
- Gap: at least one idle cycle (enable low) between consecutive requests.
- Reset asserted mid-operation aborts any request. All outputs return to reset values on the next edge.

## Structure
- Shared package: state enum, element index → byte address function, match function.
- One sub-module: `nussinov_mem_port`. It owns the request registers, the enable/finish handshake and data capture, and presents a start/busy/data interface to the sequencer.

## Test plan
- N=4, seq={1,2,1,2}, table all 0, 3-cycle response latency → 6 writes. Final table[0][3]=1, all other upper entries 0, `returnvalue`=1, `done`=1 held.
- N=4, seq all 0, table all 0 → every write is 0, `returnvalue`=0. Check request order: the first read is table[3][3]'s neighbour for (i=2,j=3), i.e. word index N+2·N+3.
- N=4, seq={1,2,1,2}, table[0][1] preset to -5 → table[0][1] is written 0 (signed max), `returnvalue`=1.
- Handshake: `read_ready` delayed 1 vs 10 cycles, and a spurious `read_ready` while idle → identical results. `finish_read` high only coincident with the accepted `read_ready`. Never both enables high.
- Reset asserted mid-run (after the 3rd write), then released → outputs zero for one cycle. The computation restarts from i=N-1 and gives the same final result.
- N=1 → no writes; `done` asserts after one read.
